// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial deserialiser.
package serial_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_deser_out_reg.sv
// Valid/ready holding register for completed words, with sticky overrun flag.
module deser_out_reg #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    input  logic         data_ready,
    input  logic         clr_flags,
    output logic [n-1:0] data_out,
    output logic         data_valid,
    output logic         overrun
);

    logic [n-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;

    // A new word is dropped only when the held word is unconsumed and not being taken now
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = clr_flags ? 1'b0 : overrun_q;
        if (in_valid) begin
            if (!valid_q || data_ready) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserialiser with per-frame bit order and a registered output stage.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic         frame_start,
    input  logic         msb_first,
    input  logic         data_ready,
    input  logic         clr_flags,
    output logic [n-1:0] data_out,
    output logic         data_valid,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);

    localparam int CW = $clog2(n + 1);

    deser_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  shift_q, shift_d;
    logic          order_q, order_d;
    logic          done_q, done_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            order_q     <= MSB_FIRST;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            order_q     <= order_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // frame_start always restarts the word; seen mid-frame it also flags the abort
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        order_d     = order_q;
        done_d      = 1'b0;
        frame_err_d = clr_flags ? 1'b0 : frame_err_q;
        if (ser_valid) begin
            if (frame_start) begin
                if (state_q == SHIFT) begin
                    frame_err_d = 1'b1;
                end
                state_d = SHIFT;
                cnt_d   = CW'(1);
                order_d = msb_first;
                if (msb_first == MSB_FIRST) begin
                    shift_d = {{(n-1){1'b0}}, ser_in};
                end else begin
                    shift_d = {ser_in, {(n-1){1'b0}}};
                end
            end else if (state_q == SHIFT) begin
                case (order_q)
                    MSB_FIRST: shift_d = {shift_q[n-2:0], ser_in};
                    LSB_FIRST: shift_d = {ser_in, shift_q[n-1:1]};
                    default:   shift_d = shift_q;
                endcase
                if (cnt_q == CW'(n - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        busy      = (state_q == SHIFT);
        frame_err = frame_err_q;
    end

    // done_q delays the hand-off so the output stage sees the completed shift register
    deser_out_reg #(
        .n(n)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (done_q),
        .in_data    (shift_q),
        .data_ready (data_ready),
        .clr_flags  (clr_flags),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Directed scoreboard bench for serial_deser at n=16.
module tb_serial_deser;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         ser_in;
    logic         ser_valid;
    logic         frame_start;
    logic         msb_first;
    logic         data_ready;
    logic         clr_flags;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int           vectors;
    int           miscompares;
    logic [N-1:0] sb_q[$];

    serial_deser #(
        .n(N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .msb_first   (msb_first),
        .data_ready  (data_ready),
        .clr_flags   (clr_flags),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic start, input logic msb, input logic clr);
        ser_valid   = 1'b1;
        ser_in      = b;
        frame_start = start;
        msb_first   = msb;
        clr_flags   = clr;
        tick();
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        clr_flags   = 1'b0;
        ser_in      = 1'b0;
    endtask

    // Sends nbits of word in the chosen order; flips msb_first mid-frame to show it is ignored
    task automatic send_word(input logic [N-1:0] word, input logic msb, input int nbits,
                             input logic gapped, input logic clr0);
        for (int i = 0; i < nbits; i++) begin
            if (gapped) begin
                repeat ($urandom_range(0, 2)) begin
                    msb_first = ~msb;
                    tick();
                end
            end
            applyStimulus(msb ? word[N-1-i] : word[i], i == 0, (i == 0) ? msb : ~msb, (i == 0) ? clr0 : 1'b0);
            if (gapped) begin
                checkOutput($sformatf("busy_bit%0d", i + 1), 64'(busy), 64'(i < N - 1));
            end
        end
    endtask

    task automatic wait_pop(input string tag);
        int budget;
        budget = 0;
        while (data_valid !== 1'b1 && budget < 8) begin
            tick();
            budget++;
        end
        checkOutput({tag, "_valid"}, 64'(data_valid), 64'(1));
        if (sb_q.size() > 0) begin
            checkOutput({tag, "_data"}, 64'(data_out), 64'(sb_q.pop_front()));
        end else begin
            checkOutput({tag, "_sb_empty"}, 64'(sb_q.size()), 64'(1));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        ser_in      = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        msb_first   = 1'b1;
        data_ready  = 1'b1;
        clr_flags   = 1'b0;

        repeat (3) tick();
        checkOutput("rst_data_out", 64'(data_out), 64'(0));
        checkOutput("rst_data_valid", 64'(data_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_overrun", 64'(overrun), 64'(0));
        checkOutput("rst_frame_err", 64'(frame_err), 64'(0));
        reset = 1'b1;

        // Bits without frame_start in IDLE are ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_ignore_busy", 64'(busy), 64'(0));

        // 0xA5C3 MSB-first: exact one-cycle latency, consumed on the next edge
        sb_q.push_back(16'hA5C3);
        send_word(16'hA5C3, 1'b1, N, 1'b0, 1'b0);
        checkOutput("msb_not_yet_valid", 64'(data_valid), 64'(0));
        checkOutput("msb_idle_busy", 64'(busy), 64'(0));
        tick();
        checkOutput("msb_lat_valid", 64'(data_valid), 64'(1));
        checkOutput("msb_lat_data", 64'(data_out), 64'(sb_q.pop_front()));
        tick();
        checkOutput("msb_consumed", 64'(data_valid), 64'(0));

        // LSB-first and alternating 1,0 pattern
        sb_q.push_back(16'hA5C3);
        send_word(16'hA5C3, 1'b0, N, 1'b0, 1'b0);
        wait_pop("lsb_a5c3");
        sb_q.push_back(16'h5555);
        send_word(16'h5555, 1'b0, N, 1'b0, 1'b0);
        wait_pop("alt_5555");
        tick();

        // Overrun: second word dropped while first unconsumed
        data_ready = 1'b0;
        sb_q.push_back(16'h1234);
        send_word(16'h1234, 1'b1, N, 1'b0, 1'b0);
        tick();
        checkOutput("ovr_first_valid", 64'(data_valid), 64'(1));
        send_word(16'hFFFF, 1'b1, N, 1'b0, 1'b0);
        tick();
        checkOutput("ovr_flag", 64'(overrun), 64'(1));
        checkOutput("ovr_valid_held", 64'(data_valid), 64'(1));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checkOutput("ovr_cleared", 64'(overrun), 64'(0));
        data_ready = 1'b1;
        wait_pop("ovr_kept_1234");
        tick();
        checkOutput("ovr_consumed", 64'(data_valid), 64'(0));

        // Completion with valid=1 and ready=1 loads the new word without overrun
        data_ready = 1'b0;
        sb_q.push_back(16'h0001);
        send_word(16'h0001, 1'b1, N, 1'b0, 1'b0);
        wait_pop("pass_a");
        send_word(16'h8000, 1'b0, N, 1'b0, 1'b0);
        sb_q.push_back(16'h8000);
        data_ready = 1'b1;
        tick();
        checkOutput("pass_b_data", 64'(data_out), 64'(sb_q.pop_front()));
        checkOutput("pass_b_valid", 64'(data_valid), 64'(1));
        checkOutput("pass_no_overrun", 64'(overrun), 64'(0));
        tick();

        // Aborted frame; restart coincides with clr_flags so the set must win
        send_word(16'h1357, 1'b1, 7, 1'b0, 1'b0);
        checkOutput("abort_busy", 64'(busy), 64'(1));
        checkOutput("abort_no_err_yet", 64'(frame_err), 64'(0));
        sb_q.push_back(16'h00FF);
        send_word(16'h00FF, 1'b1, N, 1'b0, 1'b1);
        checkOutput("abort_frame_err", 64'(frame_err), 64'(1));
        wait_pop("abort_00ff");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checkOutput("abort_err_cleared", 64'(frame_err), 64'(0));

        // Randomly gapped ser_valid over a full frame
        sb_q.push_back(16'hBEEF);
        send_word(16'hBEEF, 1'b1, N, 1'b1, 1'b0);
        wait_pop("gap_beef");
        tick();

        // Reset mid-frame, then a clean frame right after release
        send_word(16'h2468, 1'b1, 9, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_data_out", 64'(data_out), 64'(0));
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_valid", 64'(data_valid), 64'(0));
        checkOutput("mid_rst_flags", 64'({overrun, frame_err}), 64'(0));
        tick();
        reset = 1'b1;
        sb_q.push_back(16'h0F0F);
        send_word(16'h0F0F, 1'b1, N, 1'b0, 1'b0);
        checkOutput("post_rst_frame_err", 64'(frame_err), 64'(0));
        wait_pop("post_rst_0f0f");
        checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 SHALL have parameter n, default 16, output word width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ser_in  input  1  serial data bit.
REQ-005 SHALL have port ser_valid  input  1  ser_in is sampled on this clk edge.
REQ-006 SHALL have port frame_start  input  1  qualified by ser_valid; the bit presented is bit 0 of a new word.
REQ-007 SHALL have port msb_first  input  1  bit order for the frame; 1 = MSB first, 0 = LSB first.
REQ-008 SHALL have port data_ready  input  1  consumer accepts data_out this cycle.
REQ-009 SHALL have port clr_flags  input  1  synchronous clear of the sticky flags.
REQ-010 SHALL have port data_out  output  n  last completed word.
REQ-011 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-012 SHALL have port busy  output  1  a frame is partially received.
REQ-013 SHALL have port overrun  output  1  sticky; a completed word was dropped.
REQ-014 SHALL have port frame_err  output  1  sticky; a partial frame was aborted by frame_start.

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT, with a shift register and a bit counter of width clog2(n+1).
REQ-016 In IDLE, ser_valid=1 and frame_start=1 SHALL capture ser_in, latch msb_first, set the counter to 1, and enter SHIFT.
REQ-017 In IDLE, ser_valid=1 with frame_start=0 SHALL be ignored.
REQ-018 In SHIFT, each ser_valid=1 with frame_start=0 SHALL capture ser_in and increment the counter; ser_valid=0 SHALL hold all state.
REQ-019 MSB-first capture SHALL shift left and insert the new bit at bit 0; LSB-first capture SHALL shift right and insert the new bit at bit n-1.
REQ-020 Capture of the n-th bit SHALL complete the word, return the FSM to IDLE, and present the word to the output stage.
REQ-021 Output stage: data_out and data_valid SHALL update one clk after the n-th bit is sampled, giving a latency of 1 cycle.
REQ-022 data_valid SHALL stay high, with data_out stable, until data_valid=1 and data_ready=1 on the same edge.
REQ-023 A word completing while data_valid=1 and data_ready=0 SHALL be dropped, set overrun, and leave data_out unchanged.
REQ-024 A word completing while data_valid=1 and data_ready=1 SHALL load the new word, keep data_valid=1, and not set overrun.
REQ-025 frame_start=1 with ser_valid=1 in SHIFT SHALL discard the partial word, set frame_err, capture the bit as bit 0 with the counter at 1, and re-latch msb_first.
REQ-026 msb_first changes mid-frame SHALL have no effect.
REQ-027 busy SHALL equal (state == SHIFT).
REQ-028 clr_flags=1 SHALL clear overrun and frame_err.
REQ-029 A flag-setting event in the same cycle as clr_flags=1 SHALL win, leaving the flag set.
REQ-030 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-031 reset=0 SHALL asynchronously force state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, overrun=0, frame_err=0, and the latched order=MSB-first.
REQ-032 Reset asserted mid-frame SHALL discard the partial word without setting frame_err.
REQ-033 The first frame SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, SHIFT) and bit-order constants MSB_FIRST=1 and LSB_FIRST=0.
REQ-035 The output valid/ready holding register SHALL be a separate sub-module, deser_out_reg, parameterised by n.

Verification (n=16)
REQ-036 Scenario: frame_start on the first of 16 consecutive bits of 0xA5C3, MSB-first, with data_ready=1 -> data_out=0xA5C3 and data_valid=1 exactly one cycle after bit 16, then data_valid=0 on the next edge.
REQ-037 Scenario: the same bit stream sent LSB-first (bits of 0xA5C3 from bit 0 upward) -> data_out=0xA5C3; separately, 16 bits of alternating 1,0 -> 0x5555.
REQ-038 Scenario: word 0x1234 completed with data_ready=0, then a second word 0xFFFF completed -> data_out stays 0x1234 and overrun=1; clr_flags then gives overrun=0.
REQ-039 Scenario: 7 bits received, then frame_start with 16 bits of 0x00FF -> frame_err=1 and data_out=0x00FF.
REQ-040 Scenario: ser_valid gapped randomly (50% duty) over a full frame of 0xBEEF -> data_out=0xBEEF, with busy high from bit 1 until completion.
REQ-041 Scenario: reset pulsed low after 9 bits, then a clean frame of 0x0F0F -> all outputs 0 during reset, frame_err=0, data_out=0x0F0F.
